uart_mem_loader: RTL and testbench

//  Command bridge between the UART word FIFOs (uart_comm) and a single-port word memory.

---
 rtl/uart_loader_pkg.sv | 30 +++
 rtl/uart_mem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_pkg
// Brief    : Opcodes, response tags and FSM state encoding for the UART
//            memory loader command bridge.
// Revision : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    // Header opcodes (header bits [31:24])
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h50;

    // Response tags (response bits [31:24])
    localparam logic [7:0] TAG_ACK  = 8'hAC;
    localparam logic [7:0] TAG_NAK  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_DATA  = 3'd1,
        S_WR_CSUM  = 3'd2,
        S_RESP     = 3'd3,
        S_RD_ISSUE = 3'd4,
        S_RD_CAPT  = 3'd5,
        S_RD_PUSH  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Brief    : Command bridge between UART word FIFOs and a single-port word
//            memory. Executes WRITE / READ / PING packets popped from the RX
//            FIFO and answers with ACK / NAK / read-data words on the TX FIFO.
//            Optional feature macro: UART_LOADER_CSUM_EN (XOR checksum word
//            after every WRITE payload).
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_empty,
    output logic                 rx_pop,
    output logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_full,
    output logic                 tx_push,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy,
    output logic                 err
);

    localparam logic [WORD_SIZE-1:0] c_nak_word = WORD_SIZE'({TAG_NAK, 24'h000000});

    // Where a WRITE goes once its payload is exhausted
`ifdef UART_LOADER_CSUM_EN
    localparam state_t c_wr_done = S_WR_CSUM;
`else
    localparam state_t c_wr_done = S_RESP;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_len;
    logic [ADDR_W-1:0]    r_addr;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [WORD_SIZE-1:0] r_resp;
    logic                 r_err;
`ifdef UART_LOADER_CSUM_EN
    logic [WORD_SIZE-1:0] r_csum;
`endif

    logic [7:0] w_hdr_op;
    logic [7:0] w_hdr_len;
    logic       w_hdr_op_ok;

    assign w_hdr_op    = rx_data[31:24];
    assign w_hdr_len   = rx_data[23:16];
    assign w_hdr_op_ok = (w_hdr_op == OP_WRITE) || (w_hdr_op == OP_READ) ||
                         (w_hdr_op == OP_PING);

    assign busy = (r_state != S_IDLE);
    assign err  = r_err;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/memory strobes; everything held low in reset
    always_comb begin
        w_state_next = r_state;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_data      = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (!rx_empty) begin
                        rx_pop = 1'b1;
                        if (!w_hdr_op_ok) begin
                            w_state_next = S_RESP;
                        end else if (w_hdr_op == OP_WRITE) begin
                            w_state_next = (w_hdr_len == 8'd0) ? c_wr_done : S_WR_DATA;
                        end else if (w_hdr_op == OP_READ) begin
                            w_state_next = (w_hdr_len == 8'd0) ? S_RESP : S_RD_ISSUE;
                        end else begin
                            w_state_next = S_RESP;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (!rx_empty) begin
                        rx_pop    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = r_addr;
                        mem_wdata = rx_data;
                        if (r_len == 8'd1) begin
                            w_state_next = c_wr_done;
                        end
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                S_WR_CSUM: begin
                    if (!rx_empty) begin
                        rx_pop       = 1'b1;
                        w_state_next = S_RESP;
                    end
                end
`endif
                S_RESP: begin
                    tx_data = r_resp;
                    if (!tx_full) begin
                        tx_push      = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    mem_en       = 1'b1;
                    mem_addr     = r_addr;
                    w_state_next = S_RD_CAPT;
                end
                S_RD_CAPT: begin
                    w_state_next = S_RD_PUSH;
                end
                S_RD_PUSH: begin
                    tx_data = r_rdata;
                    if (!tx_full) begin
                        tx_push      = 1'b1;
                        w_state_next = (r_len == 8'd1) ? S_IDLE : S_RD_ISSUE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Header latch, address/length counters, read capture, response and error
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len   <= 8'd0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_resp  <= '0;
            r_err   <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!rx_empty) begin
                        r_len  <= w_hdr_len;
                        r_addr <= rx_data[ADDR_W-1:0];
`ifdef UART_LOADER_CSUM_EN
                        r_csum <= '0;
`endif
                        // ACK echoes the untruncated header length/address
                        if (w_hdr_op_ok) begin
                            r_resp <= WORD_SIZE'({TAG_ACK, rx_data[23:0]});
                        end else begin
                            r_resp <= c_nak_word;
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (!rx_empty) begin
                        r_addr <= r_addr + 1'b1;
                        r_len  <= r_len - 8'd1;
`ifdef UART_LOADER_CSUM_EN
                        r_csum <= r_csum ^ rx_data;
`endif
                    end
                end
`ifdef UART_LOADER_CSUM_EN
                S_WR_CSUM: begin
                    // Payload is already in memory; a bad checksum only changes the reply
                    if (!rx_empty && (rx_data != r_csum)) begin
                        r_resp <= c_nak_word;
                        r_err  <= 1'b1;
                    end
                end
`endif
                S_RD_CAPT: begin
                    r_rdata <= mem_rdata;
                end
                S_RD_PUSH: begin
                    if (!tx_full) begin
                        r_addr <= r_addr + 1'b1;
                        r_len  <= r_len - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Brief    : Self-checking bench for uart_mem_loader. FIFO and memory models
//            surround the DUT; a packet-level reference model predicts the TX
//            stream, memory contents and the error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_W    = 10;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clock     = 1'b0;
    logic              reset     = 1'b1;
    logic [31:0]       rx_data   = '0;
    logic              rx_empty  = 1'b1;
    logic              rx_pop;
    logic [31:0]       tx_data;
    logic              tx_full   = 1'b0;
    logic              tx_push;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              busy;
    logic              err;

    always #5 clock = ~clock;

    uart_mem_loader #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .tx_data(tx_data), .tx_full(tx_full), .tx_push(tx_push),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    logic [31:0] rx_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mem[0:DEPTH-1];
    logic [31:0] ref_mem[0:DEPTH-1];
    logic [31:0] rd_pend    = '0;
    bit          rd_valid   = 1'b0;
    bit          gaps_on    = 1'b0;
    bit          full_on    = 1'b0;
    bit          hold_full  = 1'b0;
    bit          exp_err    = 1'b0;
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          proto_viol = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    // Environment at the active edge: consume pops, collect pushes, serve memory
    always @(posedge clock) begin
        if (rx_pop) begin
            if (rx_empty || rx_q.size() == 0) proto_viol++;
            else void'(rx_q.pop_front());
        end
        if (tx_push) begin
            if (tx_full) proto_viol++;
            else got_q.push_back(tx_data);
        end
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        rd_valid = mem_en && !mem_we;
        if (rd_valid) rd_pend = mem[mem_addr];
    end

    // Environment mid-cycle: refresh FIFO flags/head and read data
    always @(negedge clock) begin
        rx_empty = (rx_q.size() == 0) || (gaps_on && $urandom_range(0, 3) == 0);
        rx_data  = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
        tx_full  = hold_full || (full_on && $urandom_range(0, 2) == 0);
        if (rd_valid) mem_rdata = rd_pend;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_q.delete();
        repeat (3) step();
        reset = 1'b0;
        hold_full = 1'b0;
        exp_err   = 1'b0;
        got_q.delete();
        exp_q.delete();
        step();
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (rx_q.size() == 0 && !busy && got_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- reference model: packet level ----------------
    task automatic send_write(input logic [15:0] addr, input logic [31:0] data[$]);
        logic [31:0] cs;
        cs = '0;
        rx_q.push_back({8'h57, 8'(data.size()), addr});
        for (int i = 0; i < data.size(); i++) begin
            rx_q.push_back(data[i]);
            ref_mem[(int'(addr) + i) % DEPTH] = data[i];
            cs ^= data[i];
        end
`ifdef UART_LOADER_CSUM_EN
        rx_q.push_back(cs);
`endif
        exp_q.push_back({8'hAC, 8'(data.size()), addr});
    endtask

    task automatic send_read(input logic [15:0] addr, input int len);
        rx_q.push_back({8'h52, 8'(len), addr});
        if (len == 0) exp_q.push_back({8'hAC, 8'h00, addr});
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(int'(addr) + i) % DEPTH]);
    endtask

    task automatic send_ping(input logic [15:0] addr, input int len);
        rx_q.push_back({8'h50, 8'(len), addr});
        exp_q.push_back({8'hAC, 8'(len), addr});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        rx_q.push_back(32'h5000_0000);
        repeat (3) step();
        n_tests++;
        if ({rx_pop, tx_push, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pop=%b push=%b tx=%h en=%b we=%b addr=%h wd=%h busy=%b err=%b, required all 0",
                     rx_pop, tx_push, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, err);
        end
        rx_q.delete();
        step();
        reset = 1'b0;
        step();
        n_tests++;
        if ({busy, err, rx_pop} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b err=%b pop=%b, required 000", busy, err, rx_pop);
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [31:0] d[$];
        d = '{32'h11, 32'h22, 32'h33};
        got_q.delete(); exp_q.delete();
        send_write(16'h0010, d);
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL write_ack_count: ok=%b got %0d words, required 1", ok, got_q.size());
        end else begin
            n_tests++;
            if (got_q[0] !== 32'hAC03_0010) begin
                n_fail++;
                $display("FAIL write_ack: got %h required AC030010", got_q[0]);
            end
        end
        n_tests++;
        if ({mem[16], mem[17], mem[18]} !== {32'h11, 32'h22, 32'h33}) begin
            n_fail++;
            $display("FAIL write_mem: got %h %h %h required 11 22 33", mem[16], mem[17], mem[18]);
        end
    endtask

    task automatic test_read();
        bit ok;
        got_q.delete(); exp_q.delete();
        send_read(16'h0010, 3);
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL read_count: ok=%b got %0d words, required 3", ok, got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL read_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_busy_after: got %b required 0", busy);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] d[$];
        d = '{32'hCAFE_0001, 32'hCAFE_0002};
        got_q.delete(); exp_q.delete();
        send_write(16'h03FF, d);
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 1 || got_q[0] !== 32'hAC02_03FF) begin
            n_fail++;
            $display("FAIL wrap_ack: ok=%b n=%0d got %h required AC0203FF", ok, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 32'h0);
        end
        n_tests++;
        if (mem[DEPTH-1] !== 32'hCAFE_0001 || mem[0] !== 32'hCAFE_0002) begin
            n_fail++;
            $display("FAIL wrap_mem: got top=%h zero=%h required CAFE0001 CAFE0002", mem[DEPTH-1], mem[0]);
        end
    endtask

    task automatic test_bad_op();
        bit ok;
        got_q.delete(); exp_q.delete();
        rx_q.push_back(32'h9900_0000);
        exp_q.push_back(32'hEE00_0000);
        exp_err = 1'b1;
        send_ping(16'h0000, 0);
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL badop_count: ok=%b got %0d words, required 2", ok, got_q.size());
        end else begin
            n_tests++;
            if (got_q[0] !== 32'hEE00_0000 || got_q[1] !== 32'hAC00_0000) begin
                n_fail++;
                $display("FAIL badop_resp: got %h %h required EE000000 AC000000", got_q[0], got_q[1]);
            end
        end
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL badop_err: got %b required %b", err, exp_err);
        end
    endtask

    task automatic test_read_backpressure();
        bit ok;
        int n_first;
        logic [31:0] d[$];
        for (int i = 0; i < 4; i++) d.push_back($urandom);
        got_q.delete(); exp_q.delete();
        send_write(16'h0100, d);
        wait_idle(ok);
        got_q.delete(); exp_q.delete();
        send_read(16'h0100, 4);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (got_q.size() >= 1) begin ok = 1'b1; break; end
        end
        hold_full = 1'b1;
        n_first = got_q.size();
        repeat (20) step();
        n_tests++;
        if (!ok || n_first != 1 || got_q.size() != 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall: seen=%b before=%0d after=%0d busy=%b, required 1 1 1 1",
                     ok, n_first, got_q.size(), busy);
        end
        hold_full = 1'b0;
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: ok=%b got %0d words, required 4", ok, got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got_q[i] !== d[i]) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], d[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int bad;
        got_q.delete(); exp_q.delete();
        gaps_on = 1'b1;
        full_on = 1'b1;
        for (int p = 0; p < 40; p++) begin
            logic [15:0] a;
            int          len;
            int          kind;
            logic [31:0] d[$];
            a    = 16'($urandom);
            len  = $urandom_range(0, 6);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                for (int i = 0; i < len; i++) d.push_back($urandom);
                send_write(a, d);
            end else if (kind == 1) begin
                send_read(a, len);
            end else begin
                send_ping(a, len);
            end
        end
        wait_idle(ok);
        gaps_on = 1'b0;
        full_on = 1'b0;
        n_tests++;
        if (!ok || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: ok=%b got %0d words, required %0d", ok, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_mem: %0d addresses differ, required 0", bad);
        end
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL rand_err: got %b required %b", err, exp_err);
        end
    endtask

`ifdef UART_LOADER_CSUM_EN
    task automatic test_csum();
        bit ok;
        do_reset();
        rx_q.push_back(32'h5702_0020); rx_q.push_back(32'd5); rx_q.push_back(32'd6); rx_q.push_back(32'd3);
        rx_q.push_back(32'h5702_0030); rx_q.push_back(32'd5); rx_q.push_back(32'd6); rx_q.push_back(32'd7);
        rx_q.push_back(32'h5700_0040); rx_q.push_back(32'd0);
        ref_mem[32'h20] = 32'd5; ref_mem[32'h21] = 32'd6;
        ref_mem[32'h30] = 32'd5; ref_mem[32'h31] = 32'd6;
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL csum_count: ok=%b got %0d words, required 3", ok, got_q.size());
        end else begin
            n_tests++;
            if (got_q[0] !== 32'hAC02_0020 || got_q[1] !== 32'hEE00_0000 || got_q[2] !== 32'hAC00_0040) begin
                n_fail++;
                $display("FAIL csum_resp: got %h %h %h required AC020020 EE000000 AC000040",
                         got_q[0], got_q[1], got_q[2]);
            end
        end
        n_tests++;
        if (err !== 1'b1 || mem[32'h30] !== 32'd5 || mem[32'h31] !== 32'd6) begin
            n_fail++;
            $display("FAIL csum_err_mem: err=%b mem=%h %h required 1 5 6", err, mem[32'h30], mem[32'h31]);
        end
    endtask
`endif

    task automatic test_reset_mid_write();
        bit ok;
        do_reset();
        rx_q.push_back(32'h5704_0040);
        rx_q.push_back(32'hDEAD_0000);
        rx_q.push_back(32'hDEAD_0001);
        ref_mem[32'h40] = 32'hDEAD_0000;
        ref_mem[32'h41] = 32'hDEAD_0001;
        for (int i = 0; i < 50 && rx_q.size() != 0; i++) step();
        repeat (2) step();
        n_tests++;
        if (busy !== 1'b1 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL midwr_stall: busy=%b left=%0d required 1 0", busy, rx_q.size());
        end
        reset = 1'b1;
        step();
        n_tests++;
        if ({rx_pop, tx_push, tx_data, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midwr_outputs: pop=%b push=%b en=%b we=%b, required all 0",
                     rx_pop, tx_push, mem_en, mem_we);
        end
        step();
        reset = 1'b0;
        exp_err = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b0 || mem[32'h40] !== 32'hDEAD_0000 || mem[32'h41] !== 32'hDEAD_0001) begin
            n_fail++;
            $display("FAIL midwr_after: busy=%b err=%b mem=%h %h required 0 0 DEAD0000 DEAD0001",
                     busy, err, mem[32'h40], mem[32'h41]);
        end
        got_q.delete(); exp_q.delete();
        send_ping(16'h1234, 7);
        wait_idle(ok);
        n_tests++;
        if (!ok || got_q.size() != 1 || got_q[0] !== 32'hAC07_1234) begin
            n_fail++;
            $display("FAIL midwr_ping: ok=%b n=%0d got %h required AC071234", ok, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 32'h0);
        end
    endtask

    task automatic test_protocol();
        n_tests++;
        if (proto_viol != 0) begin
            n_fail++;
            $display("FAIL handshake: %0d pop-while-empty/push-while-full events, required 0", proto_viol);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_op();
        test_read_backpressure();
        test_random();
`ifdef UART_LOADER_CSUM_EN
        test_csum();
`endif
        test_reset_mid_write();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
